damage_calc_seq: RTL and testbench
==================================

Name: damage_calc_seq

Overview:
- Multi-cycle, parametrised successor to the combinational battle damage calculator.
- Takes one attacker/defender/move record per request over a start/done handshake and computes the base damage formula with a serial divider, so there is no combinational divide by a variable.
- Applies dual-type effectiveness, STAB ×1.5 and a critical ×2, then saturates the result.
- Sits between the battle FSM and the HP-update logic; the battle FSM routes player or enemy fields onto the same ports.

Parameters:
- NUM_TYPES, 19, number of types; the type-chart dimension. Index NUM_TYPES-1 is the "none" type, neutral against everything.
- STAT_W, 8, width of the attack/defense stat inputs.
- POW_W, 8, width of move power.
- LEVEL_FACTOR, 22, the constant (2*level/5+2); 22 corresponds to level 50.
- NUM_W, 24, numerator/divider width; must hold LEVEL_FACTOR*(2^POW_W-1)*(2^STAT_W-1).
- DMG_W, 10, width of the damage output.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only while idle
- move_type  in  5  type index of the move
- move_special  in  1  1 = special move (uses spatk/spdef), 0 = physical (uses attack/defense)
- move_power  in  POW_W  base power of the move
- atk_type1, atk_type2  in  5 each  attacker's two types
- def_type1, def_type2  in  5 each  defender's two types
- atk_attack, atk_spatk  in  STAT_W each  attacker's physical and special attack stats
- def_defense, def_spdef  in  STAT_W each  defender's physical and special defense stats
- crit  in  1  apply the critical ×2
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when damage is valid
- damage  out  DMG_W  result; held until the next accepted start
- eff_q  out  7  effectiveness product in 1/16 units; values 0, 4, 8, 16, 32, 64

Behaviour:
- Clocking and reset: one clock, Clk. Reset is asynchronous and active-high.
  - Reset clears busy, done, damage and eff_q to 0 and returns the FSM to IDLE.
  - A reset asserted mid-operation aborts the calculation; no done pulse is produced.
- FSM states: IDLE, NUMER, DIV, MODIFY, DONE.
- IDLE:
  - start=1 registers every input, then goes to NUMER. busy goes high the next cycle.
  - start is ignored in every other state.
- NUMER (1 cycle):
  - num = LEVEL_FACTOR * move_power * A, where A = atk_spatk if move_special else atk_attack.
  - den = D, where D = def_spdef if move_special else def_defense; D=0 is replaced by 1.
  - Types: eff1 = chart[move_type][def_type1] and eff2 = chart[move_type][def_type2], both in quarter units (0/2/4/8). Any index >= NUM_TYPES reads as 4.
  - eff_q = eff1*eff2 is registered here.
- DIV: restoring serial divide num/den, one quotient bit per cycle, exactly NUM_W cycles.
- MODIFY (1 cycle), applied in this order, each step floored:
  - b = q/50 + 2 (constant divide)
  - b = b*eff_q/16
  - if move_type equals atk_type1 or atk_type2: b = b*3/2
  - if crit: b = b*2
  - if eff_q != 0 and b == 0: b = 1
  - saturate b to 2^DMG_W-1
  - Internal width must not overflow before saturation.
- DONE (1 cycle): done=1, damage updated, busy drops, then return to IDLE.
  - A start arriving in this cycle is ignored.
  - Back-to-back requests therefore need start in the cycle after done.
- Latency: a start accepted at cycle t gives done at cycle t+NUM_W+3, which is 27 cycles with the defaults. Latency is independent of the operand values.
- damage and eff_q hold their values in IDLE.

Decomposition:
- Package battle_pkg holds:
  - the NUM_TYPES×NUM_TYPES 4-bit type_chart constant (quarter units);
  - the type index constants, including TYPE_NONE = 18;
  - the damage FSM state enum;
  - LEVEL_FACTOR and the defaults.
- Sub-module serial_divider (width parameter NUM_W):
  - inputs: start, dividend, divisor
  - outputs: quotient, done
  - fixed NUM_W-cycle latency; reusable for stat and experience math.

Test Plan:
- Neutral hit, no STAB: power 40, attack 50, defense 50, move type 0 vs defender (0,18), attacker (1,18), physical → damage 19, eff_q 16, done exactly 27 cycles after start.
- STAB: same stimulus with attacker types (0,18) → damage 28. Add crit=1 → 56.
- Double super-effective: move type 1 vs defender (0,5), attacker (0,18), same stats → eff_q 64, damage 76. Immune: move type 0 vs defender (7,18) → eff_q 0, damage 0.
- Saturation and zero divisor: power 255, attack 255, defense 1 → 1023. Defense 0 → 1023, with no hang and done still on time.
- Special path selection: move_special=1, atk_spatk 50, def_spdef 50, atk_attack 1, def_defense 255 → 19.
- Protocol:
  - start held high continuously → one calculation per 28 cycles, and done never coincides with busy.
  - Reset asserted at cycle 10 of a calculation → busy, done and damage read 0 immediately, with no later done pulse.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared battle constants: type-effectiveness chart in quarter units, type indices,
// damage FSM state encoding and default widths/level factor.
package battle_pkg;

  localparam int NUM_TYPES_DEF    = 19;
  localparam int STAT_W_DEF       = 8;
  localparam int POW_W_DEF        = 8;
  localparam int LEVEL_FACTOR_DEF = 22;
  localparam int NUM_W_DEF        = 24;
  localparam int DMG_W_DEF        = 10;
  localparam int TYPE_W           = 5;

  localparam logic [TYPE_W-1:0] TYPE_NORMAL   = 5'd0;
  localparam logic [TYPE_W-1:0] TYPE_FIGHTING = 5'd1;
  localparam logic [TYPE_W-1:0] TYPE_FLYING   = 5'd2;
  localparam logic [TYPE_W-1:0] TYPE_POISON   = 5'd3;
  localparam logic [TYPE_W-1:0] TYPE_GROUND   = 5'd4;
  localparam logic [TYPE_W-1:0] TYPE_ROCK     = 5'd5;
  localparam logic [TYPE_W-1:0] TYPE_BUG      = 5'd6;
  localparam logic [TYPE_W-1:0] TYPE_GHOST    = 5'd7;
  localparam logic [TYPE_W-1:0] TYPE_STEEL    = 5'd8;
  localparam logic [TYPE_W-1:0] TYPE_FIRE     = 5'd9;
  localparam logic [TYPE_W-1:0] TYPE_WATER    = 5'd10;
  localparam logic [TYPE_W-1:0] TYPE_GRASS    = 5'd11;
  localparam logic [TYPE_W-1:0] TYPE_ELECTRIC = 5'd12;
  localparam logic [TYPE_W-1:0] TYPE_PSYCHIC  = 5'd13;
  localparam logic [TYPE_W-1:0] TYPE_ICE      = 5'd14;
  localparam logic [TYPE_W-1:0] TYPE_DRAGON   = 5'd15;
  localparam logic [TYPE_W-1:0] TYPE_DARK     = 5'd16;
  localparam logic [TYPE_W-1:0] TYPE_FAIRY    = 5'd17;
  localparam logic [TYPE_W-1:0] TYPE_NONE     = 5'd18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NUMER,
    S_DIV,
    S_MODIFY,
    S_DONE
  } dmg_state_e;

  // Row = attacking move type, column = defending type; 4 = x1, 8 = x2, 2 = x0.5, 0 = immune.
  localparam logic [3:0] TYPE_CHART [NUM_TYPES_DEF][NUM_TYPES_DEF] = '{
    '{4,4,4,4,4,2,4,0,2,4,4,4,4,4,4,4,4,4,4},
    '{8,4,2,2,4,8,2,0,8,4,4,4,4,2,8,4,8,2,4},
    '{4,8,4,4,4,2,8,4,2,4,4,8,2,4,4,4,4,4,4},
    '{4,4,4,2,2,2,4,2,0,4,4,8,4,4,4,4,4,8,4},
    '{4,4,0,8,4,8,2,4,8,8,4,2,8,4,4,4,4,4,4},
    '{4,2,8,4,2,4,8,4,2,8,4,4,4,4,8,4,4,4,4},
    '{4,2,2,2,4,4,4,2,2,2,4,8,4,8,4,4,8,2,4},
    '{0,4,4,4,4,4,4,8,4,4,4,4,4,8,4,4,2,4,4},
    '{4,4,4,4,4,8,4,4,2,2,2,4,2,4,8,4,4,8,4},
    '{4,4,4,4,4,2,8,4,8,2,2,8,4,4,8,2,4,4,4},
    '{4,4,4,4,8,8,4,4,4,8,2,2,4,4,4,2,4,4,4},
    '{4,4,2,2,8,8,2,4,2,2,8,2,4,4,4,2,4,4,4},
    '{4,4,8,4,0,4,4,4,4,4,8,2,2,4,4,2,4,4,4},
    '{4,8,4,8,4,4,4,4,2,4,4,4,4,2,4,4,0,4,4},
    '{4,4,8,4,8,4,4,4,2,2,2,8,4,4,2,8,4,4,4},
    '{4,4,4,4,4,4,4,4,2,4,4,4,4,4,4,8,4,0,4},
    '{4,2,4,4,4,4,4,8,4,4,4,4,4,8,4,4,2,2,4},
    '{4,8,4,2,4,4,4,4,2,2,4,4,4,4,4,8,8,4,4},
    '{4,4,4,4,4,4,4,4,4,4,4,4,4,4,4,4,4,4,4}
  };

  function automatic logic [3:0] type_eff(input logic [TYPE_W-1:0] atk,
                                          input logic [TYPE_W-1:0] dfn);
    if (int'(atk) >= NUM_TYPES_DEF || int'(dfn) >= NUM_TYPES_DEF) return 4'd4;
    return TYPE_CHART[atk][dfn];
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring serial divider: one quotient bit per cycle, done pulses NUM_W cycles after start.
// The first bit is resolved on the start edge itself; divisor 0 yields all-ones, never hangs.
module serial_divider #(
  parameter int NUM_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [NUM_W-1:0] dividend_i,
  input  logic [NUM_W-1:0] divisor_i,
  output logic [NUM_W-1:0] quotient_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] rem_q, quo_q, dvs_q;
  logic [NUM_W-1:0] rem_src, quo_src, dvs_src, rem_d, quo_d;
  logic [NUM_W:0]   trial;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    rem_src = start_i ? '0 : rem_q;
    quo_src = start_i ? dividend_i : quo_q;
    dvs_src = start_i ? divisor_i : dvs_q;
    trial   = {rem_src, quo_src[NUM_W-1]};
    if (trial >= {1'b0, dvs_src}) begin
      rem_d = NUM_W'(trial - {1'b0, dvs_src});
      quo_d = {quo_src[NUM_W-2:0], 1'b1};
    end else begin
      rem_d = trial[NUM_W-1:0];
      quo_d = {quo_src[NUM_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_o <= 1'b0;
    end else if (start_i) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= divisor_i;
      cnt_q  <= CNT_W'(NUM_W - 1);
      done_o <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q - 1'b1;
      done_o <= (cnt_q == CNT_W'(1));
    end else begin
      done_o <= 1'b0;
    end
  end

  assign quotient_o = quo_q;

endmodule

// File: rtl/damage_calc_seq.sv
// Multi-cycle battle damage calculator: start/done handshake, fixed NUM_W+3 cycle latency
// independent of operands; start is only sampled in IDLE.
module damage_calc_seq
  import battle_pkg::*;
#(
  parameter int NUM_TYPES    = NUM_TYPES_DEF,
  parameter int STAT_W       = STAT_W_DEF,
  parameter int POW_W        = POW_W_DEF,
  parameter int LEVEL_FACTOR = LEVEL_FACTOR_DEF,
  parameter int NUM_W        = NUM_W_DEF,
  parameter int DMG_W        = DMG_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [TYPE_W-1:0] move_type,
  input  logic              move_special,
  input  logic [POW_W-1:0]  move_power,
  input  logic [TYPE_W-1:0] atk_type1,
  input  logic [TYPE_W-1:0] atk_type2,
  input  logic [TYPE_W-1:0] def_type1,
  input  logic [TYPE_W-1:0] def_type2,
  input  logic [STAT_W-1:0] atk_attack,
  input  logic [STAT_W-1:0] atk_spatk,
  input  logic [STAT_W-1:0] def_defense,
  input  logic [STAT_W-1:0] def_spdef,
  input  logic              crit,
  output logic              busy,
  output logic              done,
  output logic [DMG_W-1:0]  damage,
  output logic [6:0]        eff_q
);

  localparam int MW      = NUM_W + 8;
  localparam int DMG_MAX = (1 << DMG_W) - 1;

  dmg_state_e        state_q;
  logic [TYPE_W-1:0] mt_q, at1_q, at2_q, dt1_q, dt2_q;
  logic              spec_q, crit_q;
  logic [POW_W-1:0]  pow_q;
  logic [STAT_W-1:0] attack_q, spatk_q, defense_q, spdef_q;

  logic [STAT_W-1:0] atk_sel, dfn_sel;
  logic [NUM_W-1:0]  num_d, den_d, div_quo;
  logic [3:0]        eff1, eff2;
  logic [6:0]        eff_d;
  logic              div_done;
  logic [MW-1:0]     b_base, b_eff, b_stab, b_crit, b_min;
  logic [DMG_W-1:0]  dmg_d;

  function automatic logic [3:0] chart_eff(input logic [TYPE_W-1:0] a,
                                           input logic [TYPE_W-1:0] d);
    if (int'(a) >= NUM_TYPES || int'(d) >= NUM_TYPES) return 4'd4;
    return type_eff(a, d);
  endfunction

  always_comb begin
    atk_sel = spec_q ? spatk_q : attack_q;
    dfn_sel = spec_q ? spdef_q : defense_q;
    num_d   = NUM_W'(LEVEL_FACTOR) * NUM_W'(pow_q) * NUM_W'(atk_sel);
    den_d   = (dfn_sel == '0) ? NUM_W'(1) : NUM_W'(dfn_sel);
    eff1    = chart_eff(mt_q, dt1_q);
    eff2    = chart_eff(mt_q, dt2_q);
    eff_d   = 7'(eff1) * 7'(eff2);
  end

  serial_divider #(.NUM_W(NUM_W)) u_div (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .start_i    (state_q == S_NUMER),
    .dividend_i (num_d),
    .divisor_i  (den_d),
    .quotient_o (div_quo),
    .done_o     (div_done)
  );

  // Each modifier step floors; MW leaves headroom so nothing wraps before saturation.
  always_comb begin
    b_base = MW'(div_quo / NUM_W'(50)) + MW'(2);
    b_eff  = (b_base * MW'(eff_q)) >> 4;
    b_stab = (mt_q == at1_q || mt_q == at2_q) ? ((b_eff * MW'(3)) >> 1) : b_eff;
    b_crit = crit_q ? (b_stab << 1) : b_stab;
    b_min  = (eff_q != '0 && b_crit == '0) ? MW'(1) : b_crit;
    dmg_d  = (b_min > MW'(DMG_MAX)) ? DMG_W'(DMG_MAX) : b_min[DMG_W-1:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      damage    <= '0;
      eff_q     <= '0;
      mt_q      <= '0;
      at1_q     <= '0;
      at2_q     <= '0;
      dt1_q     <= '0;
      dt2_q     <= '0;
      spec_q    <= 1'b0;
      crit_q    <= 1'b0;
      pow_q     <= '0;
      attack_q  <= '0;
      spatk_q   <= '0;
      defense_q <= '0;
      spdef_q   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start) begin
          mt_q      <= move_type;
          at1_q     <= atk_type1;
          at2_q     <= atk_type2;
          dt1_q     <= def_type1;
          dt2_q     <= def_type2;
          spec_q    <= move_special;
          crit_q    <= crit;
          pow_q     <= move_power;
          attack_q  <= atk_attack;
          spatk_q   <= atk_spatk;
          defense_q <= def_defense;
          spdef_q   <= def_spdef;
          busy      <= 1'b1;
          state_q   <= S_NUMER;
        end
        S_NUMER: begin
          eff_q   <= eff_d;
          state_q <= S_DIV;
        end
        S_DIV: if (div_done) state_q <= S_MODIFY;
        S_MODIFY: begin
          damage  <= dmg_d;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_damage_calc_seq.sv
// Directed table-driven bench for damage_calc_seq plus held-start and mid-calc reset sequences.
module tb_damage_calc_seq;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start;
  logic [4:0] move_type, atk_type1, atk_type2, def_type1, def_type2;
  logic       move_special, crit;
  logic [7:0] move_power, atk_attack, atk_spatk, def_defense, def_spdef;
  logic       busy, done;
  logic [9:0] damage;
  logic [6:0] eff_q;

  int n_cmp  = 0;
  int n_fail = 0;

  damage_calc_seq dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .move_type    (move_type),
    .move_special (move_special),
    .move_power   (move_power),
    .atk_type1    (atk_type1),
    .atk_type2    (atk_type2),
    .def_type1    (def_type1),
    .def_type2    (def_type2),
    .atk_attack   (atk_attack),
    .atk_spatk    (atk_spatk),
    .def_defense  (def_defense),
    .def_spdef    (def_spdef),
    .crit         (crit),
    .busy         (busy),
    .done         (done),
    .damage       (damage),
    .eff_q        (eff_q)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int mt, spec, pow, at1, at2, dt1, dt2, atk, spatk, dfn, spdf, crit;
    int exp_dmg, exp_eff;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    move_type    = 5'(v.mt);
    move_special = 1'(v.spec);
    move_power   = 8'(v.pow);
    atk_type1    = 5'(v.at1);
    atk_type2    = 5'(v.at2);
    def_type1    = 5'(v.dt1);
    def_type2    = 5'(v.dt2);
    atk_attack   = 8'(v.atk);
    atk_spatk    = 8'(v.spatk);
    def_defense  = 8'(v.dfn);
    def_spdef    = 8'(v.spdf);
    crit         = 1'(v.crit);
  endtask

  // lat counts posedges from the accepting edge (=1) to the one after which done is seen.
  task automatic run_one(input vec_t v, output int lat);
    apply(v);
    start = 1'b1;
    @(posedge Clk);
    lat = 1;
    @(negedge Clk);
    start = 1'b0;
    while (lat < 60 && !done) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end
  endtask

  initial begin
    int lat;
    int npulse, overlap, dones;
    int pulse_at[3];

    vecs[0]  = '{0, 0, 40, 1, 18, 0, 18, 50, 0, 50, 0, 0, 19, 16};
    vecs[1]  = '{0, 0, 40, 0, 18, 0, 18, 50, 0, 50, 0, 0, 28, 16};
    vecs[2]  = '{0, 0, 40, 0, 18, 0, 18, 50, 0, 50, 0, 1, 56, 16};
    vecs[3]  = '{1, 0, 40, 0, 18, 0, 5, 50, 0, 50, 0, 0, 76, 64};
    vecs[4]  = '{0, 0, 40, 1, 18, 7, 18, 50, 0, 50, 0, 0, 0, 0};
    vecs[5]  = '{0, 0, 255, 1, 18, 0, 18, 255, 0, 1, 0, 0, 1023, 16};
    vecs[6]  = '{0, 0, 255, 1, 18, 0, 18, 255, 0, 0, 0, 0, 1023, 16};
    vecs[7]  = '{0, 1, 40, 1, 18, 0, 18, 1, 50, 255, 50, 0, 19, 16};
    vecs[8]  = '{0, 0, 40, 0, 18, 5, 18, 50, 0, 50, 0, 0, 13, 8};
    vecs[9]  = '{1, 0, 1, 0, 18, 2, 3, 1, 0, 255, 0, 0, 1, 4};
    vecs[10] = '{25, 0, 40, 1, 18, 0, 31, 50, 0, 50, 0, 0, 19, 16};
    vecs[11] = '{9, 0, 40, 9, 18, 11, 6, 50, 0, 50, 0, 0, 114, 64};
    vecs[12] = '{12, 0, 40, 1, 18, 4, 10, 50, 0, 50, 0, 0, 0, 0};

    Reset = 1'b1;
    start = 1'b0;
    apply(vecs[0]);
    repeat (3) @(negedge Clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_damage", int'(damage), 0);
    check("rst_eff", int'(eff_q), 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < 13; i++) begin
      run_one(vecs[i], lat);
      check($sformatf("v%0d_latency", i), lat, 27);
      check($sformatf("v%0d_damage", i), int'(damage), vecs[i].exp_dmg);
      check($sformatf("v%0d_eff", i), int'(eff_q), vecs[i].exp_eff);
      check($sformatf("v%0d_busy_at_done", i), int'(busy), 0);
      repeat (3) @(negedge Clk);
      check($sformatf("v%0d_damage_hold", i), int'(damage), vecs[i].exp_dmg);
      check($sformatf("v%0d_done_low", i), int'(done), 0);
    end

    // start held high: one result every 28 cycles, done never overlaps busy
    apply(vecs[0]);
    start    = 1'b1;
    npulse   = 0;
    overlap  = 0;
    pulse_at = '{-1000, -1000, -1000};
    for (int cyc = 0; cyc < 150 && npulse < 3; cyc++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (done && busy) overlap++;
      if (done) begin
        pulse_at[npulse] = cyc;
        npulse++;
      end
    end
    start = 1'b0;
    check("held_pulses", npulse, 3);
    check("held_first", pulse_at[0], 26);
    check("held_period1", pulse_at[1] - pulse_at[0], 28);
    check("held_period2", pulse_at[2] - pulse_at[1], 28);
    check("held_overlap", overlap, 0);
    check("held_damage", int'(damage), 19);
    repeat (4) @(negedge Clk);

    // reset ten cycles into a saturating calculation
    apply(vecs[5]);
    start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    check("midrst_busy_before", int'(busy), 1);
    Reset = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_damage", int'(damage), 0);
    check("midrst_eff", int'(eff_q), 0);
    @(negedge Clk);
    Reset = 1'b0;
    dones = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge Clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_idle_busy", int'(busy), 0);

    run_one(vecs[1], lat);
    check("recover_latency", lat, 27);
    check("recover_damage", int'(damage), 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
